// File: rtl/enc_pkg.sv
// Shared types, memory map and LFSR step function for the message-encryption sequencer.
package enc_pkg;

  localparam int         MSG_LEN   = 64;
  localparam logic [7:0] SRC_LIMIT = 8'd61;
  localparam logic [7:0] PRE_ADDR  = 8'd61;
  localparam logic [7:0] TAP_ADDR  = 8'd62;
  localparam logic [7:0] SEED_ADDR = 8'd63;
  localparam logic [7:0] DST_BASE  = 8'd64;
  localparam logic [5:0] LAST_IDX  = 6'(MSG_LEN - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LD_PRE   = 3'd1,
    LD_TAP   = 3'd2,
    LD_SEED  = 3'd3,
    SEED_CAP = 3'd4,
    RUN_RD   = 3'd5,
    RUN_WR   = 3'd6,
    DONE     = 3'd7
  } state_t;

  // Shift left, feeding back the parity of the tapped bits.
  function automatic logic [6:0] lfsr_next(input logic [6:0] state7, input logic [6:0] taps7);
    return {state7[5:0], ^(state7 & taps7)};
  endfunction

endpackage

// File: rtl/encrypt_sequencer_if.sv
// Control handshake plus data-memory port between the sequencer and its host.
interface encrypt_sequencer_if;
  logic       req;
  logic       ack;
  logic       busy;
  logic [7:0] mem_addr;
  logic       mem_we;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;

  modport master (
    input  req, mem_rdata,
    output ack, busy, mem_addr, mem_we, mem_wdata
  );

  modport slave (
    output req, mem_rdata,
    input  ack, busy, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/lfsr7.sv
// 7-bit Fibonacci-style LFSR with seed load (all-zero seed becomes 1) and step.
module lfsr7
  import enc_pkg::*;
(
  input  logic       clk,
  input  logic       init_n,
  input  logic       i_load,
  input  logic       i_step,
  input  logic [6:0] i_seed,
  input  logic [6:0] i_taps,
  output logic [6:0] o_state
);

  logic [6:0] r_state;

  // LFSR state register; load has priority over step.
  always_ff @(posedge clk) begin
    if (!init_n) begin
      r_state <= 7'h00;
    end else if (i_load) begin
      r_state <= (i_seed == 7'h00) ? 7'h01 : i_seed;
    end else if (i_step) begin
      r_state <= lfsr_next(r_state, i_taps);
    end else begin
      r_state <= r_state;
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/encrypt_sequencer.sv
// Reads the job descriptor, then XORs 64 padded source bytes with an LFSR stream into DM[64..127].
module encrypt_sequencer
  import enc_pkg::*;
(
  input  logic                 clk,
  input  logic                 init_n,
  encrypt_sequencer_if.master  bus
);

  state_t     r_state;
  state_t     w_next_state;
  logic [7:0] r_pre_len;
  logic [6:0] r_taps;
  logic [5:0] r_idx;
  logic       r_ack;
  logic       r_busy;

  logic       w_preamble;
  logic [7:0] w_src_idx;
  logic       w_use_mem;
  logic [6:0] w_src;
  logic [6:0] w_lfsr;
  logic       w_load;
  logic       w_step;
  logic       w_busy_next;
  logic [7:0] w_mem_addr;
  logic       w_mem_we;
  logic [7:0] w_mem_wdata;

  // Source is zero during the preamble and past the end of the message region.
  assign w_preamble = ({2'b00, r_idx} < r_pre_len);
  assign w_src_idx  = {2'b00, r_idx} - r_pre_len;
  assign w_use_mem  = !w_preamble && (w_src_idx < SRC_LIMIT);
  assign w_src      = w_use_mem ? bus.mem_rdata[6:0] : 7'h00;

  lfsr7 u_lfsr (
    .clk     (clk),
    .init_n  (init_n),
    .i_load  (w_load),
    .i_step  (w_step),
    .i_seed  (bus.mem_rdata[6:0]),
    .i_taps  (r_taps),
    .o_state (w_lfsr)
  );

  // Sequencer state register.
  always_ff @(posedge clk) begin
    if (!init_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and memory-port decode.
  always_comb begin
    w_next_state = r_state;
    w_mem_addr   = 8'h00;
    w_mem_we     = 1'b0;
    w_mem_wdata  = 8'h00;
    w_load       = 1'b0;
    w_step       = 1'b0;
    case (r_state)
      IDLE: begin
        if (!bus.req && !r_ack) begin
          w_next_state = LD_PRE;
        end else begin
          w_next_state = IDLE;
        end
      end
      LD_PRE: begin
        w_mem_addr   = PRE_ADDR;
        w_next_state = LD_TAP;
      end
      LD_TAP: begin
        w_mem_addr   = TAP_ADDR;
        w_next_state = LD_SEED;
      end
      LD_SEED: begin
        w_mem_addr   = SEED_ADDR;
        w_next_state = SEED_CAP;
      end
      SEED_CAP: begin
        w_load       = 1'b1;
        w_next_state = RUN_RD;
      end
      RUN_RD: begin
        if (w_use_mem) begin
          w_mem_addr = w_src_idx;
        end else begin
          w_mem_addr = 8'h00;
        end
        w_next_state = RUN_WR;
      end
      RUN_WR: begin
        w_mem_we    = 1'b1;
        w_mem_addr  = DST_BASE + {2'b00, r_idx};
        w_mem_wdata = {1'b0, w_src ^ w_lfsr};
        w_step      = 1'b1;
        if (r_idx == LAST_IDX) begin
          w_next_state = DONE;
        end else begin
          w_next_state = RUN_RD;
        end
      end
      DONE: begin
        if (bus.req) begin
          w_next_state = IDLE;
        end else begin
          w_next_state = DONE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  assign w_busy_next = (w_next_state != IDLE) && (w_next_state != DONE);

  // Descriptor capture, byte index and registered status flags.
  always_ff @(posedge clk) begin
    if (!init_n) begin
      r_pre_len <= 8'h00;
      r_taps    <= 7'h00;
      r_idx     <= 6'd0;
      r_ack     <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_ack  <= (w_next_state == DONE);
      r_busy <= w_busy_next;
      if (r_state == LD_TAP) begin
        r_pre_len <= bus.mem_rdata;
      end else begin
        r_pre_len <= r_pre_len;
      end
      if (r_state == LD_SEED) begin
        r_taps <= bus.mem_rdata[6:0];
      end else begin
        r_taps <= r_taps;
      end
      if (r_state == SEED_CAP) begin
        r_idx <= 6'd0;
      end else if (r_state == RUN_WR) begin
        r_idx <= r_idx + 6'd1;
      end else begin
        r_idx <= r_idx;
      end
    end
  end

  assign bus.ack       = r_ack;
  assign bus.busy      = r_busy;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_wdata = w_mem_wdata;

endmodule

// File: tb/tb_encrypt_sequencer.sv
// Bench for encrypt_sequencer: table of jobs checked by a write scoreboard, plus handshake/reset sequences.
module tb_encrypt_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic init_n;
  encrypt_sequencer_if bus_if ();

  encrypt_sequencer dut (
    .clk    (clk),
    .init_n (init_n),
    .bus    (bus_if)
  );

  logic [7:0] mem [0:255];
  logic       ld_en;
  logic [7:0] ld_addr;
  logic [7:0] ld_data;

  // Synchronous-read data memory with a bench load port.
  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (bus_if.mem_we) mem[bus_if.mem_addr] <= bus_if.mem_wdata;
    bus_if.mem_rdata <= mem[bus_if.mem_addr];
  end

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  typedef struct {
    logic [7:0] pre;
    logic [7:0] taps;
    logic [7:0] seed;
    int         msg;
    int         chk_idx;
    logic [7:0] chk_val;
    bit         same_as_ref;
  } vec_t;

  wr_t        sb_q[$];
  int         checks = 0;
  int         errors = 0;
  int         wr_count = 0;
  logic [7:0] img [0:63];
  logic [7:0] last_out [0:63];
  logic [7:0] ref_out [0:63];
  vec_t       vt [0:15];

  function automatic logic [6:0] step7(input logic [6:0] s, input logic [6:0] t);
    return {s[5:0], ^(s & t)};
  endfunction

  function automatic logic [6:0] lfsr_at(input logic [7:0] seed, input logic [7:0] taps, input int n);
    logic [6:0] l;
    l = (seed[6:0] == 7'h00) ? 7'h01 : seed[6:0];
    for (int k = 0; k < n; k++) l = step7(l, taps[6:0]);
    return l;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp_v);
    end
  endtask

  // One clock; sample just after the edge and score any write about to commit.
  task automatic tick();
    wr_t e_w;
    @(posedge clk);
    #1;
    if (bus_if.mem_we == 1'b1) begin
      wr_count++;
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%02h data=%02h required=no_write",
                 bus_if.mem_addr, bus_if.mem_wdata);
      end else begin
        e_w = sb_q.pop_front();
        if (bus_if.mem_addr !== e_w.addr || bus_if.mem_wdata !== e_w.data) begin
          errors++;
          $display("FAIL wr_byte addr=%02h data=%02h required addr=%02h data=%02h",
                   bus_if.mem_addr, bus_if.mem_wdata, e_w.addr, e_w.data);
        end
      end
    end
  endtask

  task automatic build_image(input int msg, input logic [7:0] pre, input logic [7:0] taps,
                             input logic [7:0] seed);
    string s;
    s = "Mr. Watson, come here. I want to see you.";
    for (int k = 0; k < 61; k++) begin
      if (msg == 0) img[k] = (k < s.len()) ? (8'(s[k]) - 8'h20) : 8'h00;
      else          img[k] = 8'((k * 37 + 11) & 255);
    end
    img[61] = pre;
    img[62] = taps;
    img[63] = seed;
    for (int k = 0; k < 128; k++) begin
      ld_en   = 1'b1;
      ld_addr = 8'(k);
      ld_data = (k < 64) ? img[k] : 8'hEE;
      tick();
    end
    ld_en = 1'b0;
  endtask

  task automatic push_expected();
    logic [6:0] l;
    logic [7:0] src;
    wr_t        w;
    int         s;
    l = (img[63][6:0] == 7'h00) ? 7'h01 : img[63][6:0];
    for (int i = 0; i < 64; i++) begin
      if (i < int'(img[61])) begin
        src = 8'h00;
      end else begin
        s   = i - int'(img[61]);
        src = (s < 61) ? img[s] : 8'h00;
      end
      w.addr = 8'(64 + i);
      w.data = {1'b0, src[6:0] ^ l};
      sb_q.push_back(w);
      l = step7(l, img[62][6:0]);
    end
  endtask

  // Launch one job from idle and wait for ack; leaves req low.
  task automatic do_run(input int msg, input logic [7:0] pre, input logic [7:0] taps,
                        input logic [7:0] seed);
    int cyc;
    bus_if.req = 1'b1;
    tick();
    build_image(msg, pre, taps, seed);
    push_expected();
    bus_if.req = 1'b0;
    tick();
    chk("launch_busy", 32'(bus_if.busy), 32'd1);
    cyc = 0;
    while (bus_if.ack !== 1'b1 && cyc < 400) begin
      tick();
      cyc++;
    end
    chk("ack_latency", 32'(cyc), 32'd132);
    chk("busy_at_ack", 32'(bus_if.busy), 32'd0);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    sb_q.delete();
    for (int i = 0; i < 64; i++) last_out[i] = mem[64 + i];
  endtask

  task automatic release_req();
    bus_if.req = 1'b1;
    tick();
    chk("ack_clear", 32'(bus_if.ack), 32'd0);
  endtask

  initial begin
    int   w0;
    int   bad;
    logic found;

    // Job table: spec example, seed variants, boundaries, then a random-seed tap sweep.
    vt[0] = '{8'd10, 8'h60, 8'h01, 0, 0,  8'h01, 1'b0};
    vt[1] = '{8'd10, 8'h60, 8'h01, 0, 6,  8'h41, 1'b1};
    vt[2] = '{8'd10, 8'h60, 8'h01, 0, 10, 8'h35, 1'b1};
    vt[3] = '{8'd10, 8'h60, 8'h00, 0, 0,  8'h01, 1'b1};
    vt[4] = '{8'd10, 8'h60, 8'h81, 0, 9,  8'h0C, 1'b1};
    vt[5] = '{8'd0,  8'h60, 8'h01, 1, 63, {1'b0, lfsr_at(8'h01, 8'h60, 63)}, 1'b0};
    vt[6] = '{8'd70, 8'h48, 8'h2B, 0, 40, {1'b0, lfsr_at(8'h2B, 8'h48, 40)}, 1'b0};
    begin
      logic [7:0] taps_list [0:8];
      taps_list = '{8'h60, 8'h48, 8'h78, 8'h72, 8'h6A, 8'h69, 8'h5C, 8'h7E, 8'h7B};
      for (int k = 0; k < 9; k++)
        vt[7 + k] = '{8'($urandom_range(10, 15)), taps_list[k], 8'($urandom_range(0, 255)),
                      0, -1, 8'h00, 1'b0};
    end

    init_n        = 1'b0;
    bus_if.req    = 1'b1;
    ld_en         = 1'b0;
    ld_addr       = 8'h00;
    ld_data       = 8'h00;
    repeat (3) tick();
    chk("rst_ack",   32'(bus_if.ack),       32'd0);
    chk("rst_busy",  32'(bus_if.busy),      32'd0);
    chk("rst_we",    32'(bus_if.mem_we),    32'd0);
    chk("rst_addr",  32'(bus_if.mem_addr),  32'd0);
    chk("rst_wdata", 32'(bus_if.mem_wdata), 32'd0);
    init_n = 1'b1;

    w0  = wr_count;
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (bus_if.busy !== 1'b0) bad++;
    end
    chk("hold_req_busy",   32'(bad), 32'd0);
    chk("hold_req_writes", 32'(wr_count - w0), 32'd0);

    for (int e = 0; e < 16; e++) begin
      do_run(vt[e].msg, vt[e].pre, vt[e].taps, vt[e].seed);
      if (vt[e].chk_idx >= 0)
        chk($sformatf("vec%0d_byte%0d", e, vt[e].chk_idx), 32'(last_out[vt[e].chk_idx]),
            32'(vt[e].chk_val));
      if (vt[e].same_as_ref) begin
        bad = 0;
        for (int i = 0; i < 64; i++) if (last_out[i] !== ref_out[i]) bad++;
        chk($sformatf("vec%0d_same_as_ref", e), 32'(bad), 32'd0);
      end
      if (e == 0) begin
        for (int i = 0; i < 64; i++) ref_out[i] = last_out[i];
        w0  = wr_count;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
          tick();
          if (bus_if.ack !== 1'b1) bad++;
        end
        chk("ack_hold",  32'(bad), 32'd0);
        chk("no_rerun",  32'(wr_count - w0), 32'd0);
      end
      release_req();
    end

    // Abort a run at byte 20 with reset, then rerun the same job.
    build_image(1, 8'd12, 8'h78, 8'h55);
    push_expected();
    bus_if.req = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      tick();
      if (bus_if.mem_we === 1'b1 && bus_if.mem_addr == 8'd84) found = 1'b1;
    end
    chk("abort_reached_i20", 32'(found), 32'd1);
    init_n = 1'b0;
    tick();
    chk("abort_ack",  32'(bus_if.ack),    32'd0);
    chk("abort_busy", 32'(bus_if.busy),   32'd0);
    chk("abort_we",   32'(bus_if.mem_we), 32'd0);
    sb_q.delete();
    bus_if.req = 1'b1;
    tick();
    init_n = 1'b1;
    tick();
    do_run(1, 8'd12, 8'h78, 8'h55);
    release_req();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
